// File: rtl/fifo_level.sv
// Single-clock FWFT FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module fifo_level #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic wr_ok;
    logic rd_ok;
    logic ovf_set;
    logic udf_set;

    // Status is derived from registered count only, so no rd/wr-to-flag path exists.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign r_data       = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign wr_ok   = wr & (~full | rd);
    assign rd_ok   = rd & ~empty;
    assign ovf_set = ~flush & wr & full & ~rd;
    assign udf_set = ~flush & rd & empty;

    always_ff @(posedge clk) begin
        if (reset && !flush && wr_ok) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_err) | ovf_set;
            udf_q <= (udf_q & ~clr_err) | udf_set;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                case ({wr_ok, rd_ok})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level: fill, overflow, full/empty
// simultaneous access, flush and mid-operation reset.
module tb_fifo_level;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic        flush;
    logic        clr_err;
    logic [23:0] w_data;
    logic [23:0] r_data;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    fifo_level #(
        .DATA_WIDTH(24),
        .ADDR_WIDTH(3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd          (rd),
        .wr          (wr),
        .flush       (flush),
        .clr_err     (clr_err),
        .w_data      (w_data),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rd = 1'b0; wr = 1'b0; flush = 1'b0; clr_err = 1'b0; reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        checks++; if (count !== 4'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0)  begin failures++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
        checks++; if (r_data !== 24'h0)  begin failures++; $display("FAIL reset_rdata got=%0h exp=0", r_data); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%0b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; w_data = 24'(i);
            step();
            checks++; if (count !== 4'(i)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            checks++; if (almost_empty !== (i <= 2)) begin failures++; $display("FAIL fill_ae[%0d] got=%0b exp=%0b", i, almost_empty, (i <= 2)); end
            checks++; if (almost_full !== (i >= 6)) begin failures++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, almost_full, (i >= 6)); end
            checks++; if (full !== (i == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == 8)); end
            checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%0b exp=0", i, empty); end
            checks++; if (r_data !== 24'h000001) begin failures++; $display("FAIL fill_rdata[%0d] got=%0h exp=1", i, r_data); end
        end
    endtask

    task automatic test_overflow();
        wr = 1'b1; w_data = 24'hABCDEF;
        step();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (count !== 4'd8)    begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (r_data !== 24'h000001) begin failures++; $display("FAIL ovf_rdata got=%0h exp=1", r_data); end
        clr_err = 1'b1;
        step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_back_to_back_full();
        logic [23:0] exp_r;
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1; wr = 1'b1; w_data = 24'h100 + 24'(i);
            step();
            exp_r = (i < 7) ? 24'(i + 2) : 24'h100;
            checks++; if (count !== 4'd8) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=8", i, count); end
            checks++; if (full !== 1'b1)  begin failures++; $display("FAIL b2b_full[%0d] got=%0b exp=1", i, full); end
            checks++; if (r_data !== exp_r) begin failures++; $display("FAIL b2b_rdata[%0d] got=%0h exp=%0h", i, r_data, exp_r); end
        end
        for (int i = 0; i < 8; i++) begin
            exp_r = 24'h100 + 24'(i);
            checks++; if (r_data !== exp_r) begin failures++; $display("FAIL drain_rdata[%0d] got=%0h exp=%0h", i, r_data, exp_r); end
            rd = 1'b1;
            step();
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL drain_empty got=%0b/%0d exp=1/0", empty, count); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drain_udf got=%0b exp=0", underflow); end
    endtask

    task automatic test_empty_rdwr();
        rd = 1'b1; wr = 1'b1; w_data = 24'h55;
        step();
        checks++; if (count !== 4'd1)     begin failures++; $display("FAIL erw_count got=%0d exp=1", count); end
        checks++; if (r_data !== 24'h55)  begin failures++; $display("FAIL erw_rdata got=%0h exp=55", r_data); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL erw_udf got=%0b exp=1", underflow); end
        rd = 1'b1;
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL erw_pop got=%0b exp=1", empty); end
        rd = 1'b1; clr_err = 1'b1;
        step();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_clr_collide got=%0b exp=1", underflow); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL udf_ignored got=%0d exp=0", count); end
        clr_err = 1'b1;
        step();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%0b exp=0", underflow); end
    endtask

    task automatic test_flush();
        rd = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; w_data = 24'h11 + 24'(i);
            step();
        end
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", count); end
        flush = 1'b1; rd = 1'b1; wr = 1'b1; w_data = 24'h99;
        step();
        checks++; if (count !== 4'd0)    begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL flush_empty got=%0b exp=1", empty); end
        checks++; if (r_data !== 24'h0)  begin failures++; $display("FAIL flush_rdata got=%0h exp=0", r_data); end
        checks++; if ({overflow, underflow} !== 2'b01) begin failures++; $display("FAIL flush_err got=%0b exp=01", {overflow, underflow}); end
        wr = 1'b1; w_data = 24'h77;
        step();
        checks++; if (r_data !== 24'h77 || count !== 4'd1) begin failures++; $display("FAIL flush_after got=%0h/%0d exp=77/1", r_data, count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; w_data = 24'h20 + 24'(i);
            step();
        end
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL rstm_pre got=%0d exp=4", count); end
        reset = 1'b0; wr = 1'b1; w_data = 24'hEE;
        step();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstm_count got=%0d exp=0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin failures++; $display("FAIL rstm_flags got=%0b exp=1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL rstm_err got=%0b exp=00", {overflow, underflow}); end
        checks++; if (r_data !== 24'h0) begin failures++; $display("FAIL rstm_rdata got=%0h exp=0", r_data); end
    endtask

    initial begin
        idle();
        w_data = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back_full();
        test_empty_rdwr();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
